// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: memory op codes, FSM state encodings and op classification helpers
package mem_stage_pkg;
    typedef logic [3:0] mem_op_t;

    localparam mem_op_t MEM_NONE = 4'd0;
    localparam mem_op_t MEM_LB   = 4'd1;
    localparam mem_op_t MEM_LH   = 4'd2;
    localparam mem_op_t MEM_LW   = 4'd3;
    localparam mem_op_t MEM_LBU  = 4'd4;
    localparam mem_op_t MEM_LHU  = 4'd5;
    localparam mem_op_t MEM_SB   = 4'd6;
    localparam mem_op_t MEM_SH   = 4'd7;
    localparam mem_op_t MEM_SW   = 4'd8;

    localparam logic [1:0] MEM_IDLE        = 2'd0;
    localparam logic [1:0] MEM_WAIT_GNT    = 2'd1;
    localparam logic [1:0] MEM_WAIT_RVALID = 2'd2;

    function automatic logic is_load(input mem_op_t op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic logic misaligned(input mem_op_t op, input logic [1:0] off);
        return (op inside {MEM_LH, MEM_LHU, MEM_SH} && off[0]) || (op inside {MEM_LW, MEM_SW} && off != 2'd0);
    endfunction
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: ex_mem_reg inputs, writeback outputs and data-memory port of the memory stage.
// mem_misalign_o exists only when MEM_MISALIGN_TRAP_EN is defined.
interface mem_stage_if;
    import mem_stage_pkg::*;
    logic        ex_mem_reg_valid_i;
    logic [31:0] ex_mem_reg_op_c_i;
    logic [31:0] ex_mem_reg_store_data_i;
    mem_op_t     ex_mem_reg_mem_op_i;
    logic [4:0]  ex_mem_reg_reg_waddr_i;
    logic        ex_mem_reg_reg_we_i;
    logic [31:0] mem_reg_wdata_o;
    logic [4:0]  mem_reg_waddr_o;
    logic        mem_reg_we_o;
    logic        mem_valid_o;
    logic        mem_stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        mem_misalign_o;
`endif

    modport master (
        input  ex_mem_reg_valid_i, ex_mem_reg_op_c_i, ex_mem_reg_store_data_i, ex_mem_reg_mem_op_i,
               ex_mem_reg_reg_waddr_i, ex_mem_reg_reg_we_i, dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
        output mem_reg_wdata_o, mem_reg_waddr_o, mem_reg_we_o, mem_valid_o, mem_stall_o,
               dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o
`ifdef MEM_MISALIGN_TRAP_EN
        , output mem_misalign_o
`endif
    );

    modport slave (
        output ex_mem_reg_valid_i, ex_mem_reg_op_c_i, ex_mem_reg_store_data_i, ex_mem_reg_mem_op_i,
               ex_mem_reg_reg_waddr_i, ex_mem_reg_reg_we_i, dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
        input  mem_reg_wdata_o, mem_reg_waddr_o, mem_reg_we_o, mem_valid_o, mem_stall_o,
               dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o
`ifdef MEM_MISALIGN_TRAP_EN
        , input mem_misalign_o
`endif
    );
endinterface

// File: rtl/mem_stage_load_align.sv
// load_align: selects the byte/halfword lane of returned load data and sign- or zero-extends it
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  mem_op_t     op,
    output logic [31:0] result
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = 8'(rdata >> {offset, 3'b000});
        h = offset[1] ? rdata[31:16] : rdata[15:0];
        result = op == MEM_LB  ? {{24{b[7]}}, b} :
                 op == MEM_LBU ? {24'd0, b} :
                 op == MEM_LH  ? {{16{h[15]}}, h} :
                 op == MEM_LHU ? {16'd0, h} : rdata;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store stage with req/gnt/rvalid data-memory handshake and pipeline stall.
// Optional misaligned-access trap enabled by MEM_MISALIGN_TRAP_EN.
module mem_stage
    import mem_stage_pkg::*;
(
    input logic        clk,
    input logic        rst_n,
    mem_stage_if.master bus
);
    logic [1:0]  state, state_n, a, off_q;
    mem_op_t     op, op_q;
    logic [31:0] sd, ld_data;
    logic        none, mem, mis, req, st_done, ld_done;

    load_align u_align (.rdata(bus.dmem_rdata_i), .offset(off_q), .op(op_q), .result(ld_data));

    always_comb begin
        op = bus.ex_mem_reg_mem_op_i;
        a = bus.ex_mem_reg_op_c_i[1:0];
        sd = bus.ex_mem_reg_store_data_i;
        none = bus.ex_mem_reg_valid_i && op == MEM_NONE;
        mem = bus.ex_mem_reg_valid_i && (is_load(op) || is_store(op));
`ifdef MEM_MISALIGN_TRAP_EN
        mis = mem && state == MEM_IDLE && misaligned(op, a);
`else
        mis = 1'b0;
`endif
        req = mem && !mis && state != MEM_WAIT_RVALID;
        st_done = req && bus.dmem_gnt_i && is_store(op);
        // rvalid only counts once a load has actually been granted
        ld_done = state == MEM_WAIT_RVALID && bus.dmem_rvalid_i;
        state_n = state == MEM_WAIT_RVALID ? (bus.dmem_rvalid_i ? MEM_IDLE : MEM_WAIT_RVALID) :
                  !req ? MEM_IDLE :
                  !bus.dmem_gnt_i ? MEM_WAIT_GNT :
                  is_load(op) ? MEM_WAIT_RVALID : MEM_IDLE;
        bus.dmem_req_o = rst_n && req;
        bus.dmem_we_o = rst_n && req && is_store(op);
        bus.dmem_addr_o = (rst_n && req) ? {bus.ex_mem_reg_op_c_i[31:2], 2'b00} : 32'd0;
        bus.dmem_be_o = !(rst_n && req) ? 4'd0 :
                        op == MEM_SB ? 4'b0001 << a :
                        op == MEM_SH ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        bus.dmem_wdata_o = !(rst_n && req) ? 32'd0 :
                           op == MEM_SB ? {4{sd[7:0]}} :
                           op == MEM_SH ? {2{sd[15:0]}} :
                           op == MEM_SW ? sd : 32'd0;
        bus.mem_valid_o = rst_n && (none || st_done || ld_done || mis);
        bus.mem_reg_we_o = rst_n && (none || ld_done) && bus.ex_mem_reg_reg_we_i;
        bus.mem_reg_waddr_o = rst_n ? bus.ex_mem_reg_reg_waddr_i : 5'd0;
        bus.mem_reg_wdata_o = !rst_n ? 32'd0 : none ? bus.ex_mem_reg_op_c_i : ld_done ? ld_data : 32'd0;
        bus.mem_stall_o = rst_n && mem && !mis && !st_done && !ld_done;
`ifdef MEM_MISALIGN_TRAP_EN
        bus.mem_misalign_o = rst_n && mis;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= MEM_IDLE;
            off_q <= 2'd0;
            op_q <= MEM_NONE;
        end else begin
            state <= state_n;
            if (req && bus.dmem_gnt_i && is_load(op)) begin
                off_q <= a;
                op_q <= op;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table vectors, directed corner sequences and randomized transactions against a behavioural model
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if bus();
    mem_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic v; mem_op_t op; logic [31:0] opc, sd; logic [4:0] wa; logic we; logic gnt;
        logic e_req, e_dwe; logic [31:0] e_addr, e_dw; logic [3:0] e_be;
        logic e_valid, e_rwe; logic [31:0] e_rwdata; logic e_stall;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input mem_op_t op, input logic [31:0] opc, sd, input logic [4:0] wa, input logic we);
        bus.ex_mem_reg_valid_i = v;
        bus.ex_mem_reg_mem_op_i = op;
        bus.ex_mem_reg_op_c_i = opc;
        bus.ex_mem_reg_store_data_i = sd;
        bus.ex_mem_reg_reg_waddr_i = wa;
        bus.ex_mem_reg_reg_we_i = we;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".req"}, bus.dmem_req_o, 0);
        chk({tag, ".dwe"}, bus.dmem_we_o, 0);
        chk({tag, ".addr"}, bus.dmem_addr_o, 0);
        chk({tag, ".dwdata"}, bus.dmem_wdata_o, 0);
        chk({tag, ".be"}, bus.dmem_be_o, 0);
        chk({tag, ".valid"}, bus.mem_valid_o, 0);
        chk({tag, ".rwe"}, bus.mem_reg_we_o, 0);
        chk({tag, ".rwdata"}, bus.mem_reg_wdata_o, 0);
        chk({tag, ".stall"}, bus.mem_stall_o, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk({tag, ".misalign"}, bus.mem_misalign_o, 0);
`endif
    endtask

    function automatic logic m_store(input mem_op_t op);
        return op == MEM_SB || op == MEM_SH || op == MEM_SW;
    endfunction

    function automatic logic [3:0] m_be(input mem_op_t op, input logic [31:0] addr);
        if (op == MEM_SB) return 4'(2 ** (addr % 4));
        if (op == MEM_SH) return (addr % 4) / 2 == 1 ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input mem_op_t op, input logic [31:0] sd);
        if (op == MEM_SB) return (sd & 32'hFF) * 32'h0101_0101;
        if (op == MEM_SH) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] m_load(input mem_op_t op, input logic [31:0] addr, rdata);
        int unsigned b = (rdata >> ((addr % 4) * 8)) & 32'hFF;
        int unsigned h = (rdata >> ((addr % 4) / 2 * 16)) & 32'hFFFF;
        case (op)
            MEM_LB:  return b >= 128 ? b - 256 : b;
            MEM_LH:  return h >= 32768 ? h - 65536 : h;
            MEM_LBU: return b;
            MEM_LHU: return h;
            default: return rdata;
        endcase
    endfunction

    // one complete transaction from IDLE: gd grant-wait cycles, rd extra cycles before rvalid
    task automatic txn(input string tag, input mem_op_t op, input logic [31:0] opc, sd, rdata,
                       input int gd, rd, input logic [4:0] wa, input logic we,
                       input logic [31:0] e_wb, input logic [3:0] e_be, input logic [31:0] e_dw);
        logic st = m_store(op);
        drive(1'b1, op, opc, sd, wa, we);
        bus.dmem_gnt_i = 1'b0;
        bus.dmem_rvalid_i = 1'b0;
        bus.dmem_rdata_i = $urandom;
        if (op == MEM_NONE) begin
            #1;
            chk({tag, ".valid"}, bus.mem_valid_o, 1);
            chk({tag, ".rwdata"}, bus.mem_reg_wdata_o, e_wb);
            chk({tag, ".rwe"}, bus.mem_reg_we_o, we);
            chk({tag, ".waddr"}, bus.mem_reg_waddr_o, wa);
            chk({tag, ".stall"}, bus.mem_stall_o, 0);
            chk({tag, ".req"}, bus.dmem_req_o, 0);
            @(negedge clk);
            return;
        end
        for (int c = 0; c < gd; c++) begin
            #1;
            chk({tag, ".wait_req"}, bus.dmem_req_o, 1);
            chk({tag, ".wait_stall"}, bus.mem_stall_o, 1);
            chk({tag, ".wait_valid"}, bus.mem_valid_o, 0);
            chk({tag, ".wait_addr"}, bus.dmem_addr_o, opc & ~32'd3);
            chk({tag, ".wait_be"}, bus.dmem_be_o, e_be);
            @(negedge clk);
        end
        bus.dmem_gnt_i = 1'b1;
        #1;
        chk({tag, ".req"}, bus.dmem_req_o, 1);
        chk({tag, ".dwe"}, bus.dmem_we_o, st);
        chk({tag, ".addr"}, bus.dmem_addr_o, opc & ~32'd3);
        chk({tag, ".be"}, bus.dmem_be_o, e_be);
        if (st) begin
            chk({tag, ".dwdata"}, bus.dmem_wdata_o, e_dw);
            chk({tag, ".valid"}, bus.mem_valid_o, 1);
            chk({tag, ".rwe"}, bus.mem_reg_we_o, 0);
            chk({tag, ".stall"}, bus.mem_stall_o, 0);
            @(negedge clk);
            bus.dmem_gnt_i = 1'b0;
            return;
        end
        chk({tag, ".gnt_stall"}, bus.mem_stall_o, 1);
        chk({tag, ".gnt_valid"}, bus.mem_valid_o, 0);
        @(negedge clk);
        bus.dmem_gnt_i = 1'b0;
        for (int c = 0; c < rd; c++) begin
            #1;
            chk({tag, ".rv_stall"}, bus.mem_stall_o, 1);
            chk({tag, ".rv_req"}, bus.dmem_req_o, 0);
            chk({tag, ".rv_valid"}, bus.mem_valid_o, 0);
            @(negedge clk);
        end
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i = rdata;
        #1;
        chk({tag, ".valid"}, bus.mem_valid_o, 1);
        chk({tag, ".rwdata"}, bus.mem_reg_wdata_o, e_wb);
        chk({tag, ".rwe"}, bus.mem_reg_we_o, we);
        chk({tag, ".stall"}, bus.mem_stall_o, 0);
        @(negedge clk);
        bus.dmem_rvalid_i = 1'b0;
    endtask

    vec_t vt[9];

    initial begin
        vt[0] = '{1, MEM_NONE, 32'h1234_5678, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1234_5678, 0};
        vt[1] = '{0, MEM_SW, 32'h0000_0400, 32'h5555_5555, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[2] = '{1, MEM_SB, 32'h0000_0100, 32'h0000_00AB, 1, 1, 1, 1, 1, 32'h100, 32'hABAB_ABAB, 4'h1, 1, 0, 0, 0};
        vt[3] = '{1, MEM_SB, 32'h0000_0101, 32'h1122_33CD, 1, 1, 1, 1, 1, 32'h100, 32'hCDCD_CDCD, 4'h2, 1, 0, 0, 0};
        vt[4] = '{1, MEM_SB, 32'hFFFF_FFFF, 32'h0000_00EF, 1, 0, 1, 1, 1, 32'hFFFF_FFFC, 32'hEFEF_EFEF, 4'h8, 1, 0, 0, 0};
        vt[5] = '{1, MEM_SH, 32'h0000_0202, 32'hDEAD_BEEF, 2, 1, 1, 1, 1, 32'h200, 32'hBEEF_BEEF, 4'hC, 1, 0, 0, 0};
        vt[6] = '{1, MEM_SH, 32'h0000_0200, 32'h1234_5678, 2, 1, 1, 1, 1, 32'h200, 32'h5678_5678, 4'h3, 1, 0, 0, 0};
        vt[7] = '{1, MEM_SW, 32'h0000_0300, 32'hCAFE_F00D, 2, 1, 1, 1, 1, 32'h300, 32'hCAFE_F00D, 4'hF, 1, 0, 0, 0};
        vt[8] = '{1, MEM_NONE, 32'hFFFF_FFFF, 0, 31, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0};

        drive(1'b1, MEM_NONE, 32'h1234_5678, 0, 5'd5, 1'b1);
        bus.dmem_gnt_i = 1'b0;
        bus.dmem_rvalid_i = 1'b0;
        bus.dmem_rdata_i = 32'd0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i].v, vt[i].op, vt[i].opc, vt[i].sd, vt[i].wa, vt[i].we);
            bus.dmem_gnt_i = vt[i].gnt;
            #1;
            chk($sformatf("vec%0d.req", i), bus.dmem_req_o, vt[i].e_req);
            chk($sformatf("vec%0d.dwe", i), bus.dmem_we_o, vt[i].e_dwe);
            if (vt[i].e_req) begin
                chk($sformatf("vec%0d.addr", i), bus.dmem_addr_o, vt[i].e_addr);
                chk($sformatf("vec%0d.dwdata", i), bus.dmem_wdata_o, vt[i].e_dw);
                chk($sformatf("vec%0d.be", i), bus.dmem_be_o, vt[i].e_be);
            end
            chk($sformatf("vec%0d.valid", i), bus.mem_valid_o, vt[i].e_valid);
            chk($sformatf("vec%0d.rwe", i), bus.mem_reg_we_o, vt[i].e_rwe);
            chk($sformatf("vec%0d.rwdata", i), bus.mem_reg_wdata_o, vt[i].e_rwdata);
            chk($sformatf("vec%0d.stall", i), bus.mem_stall_o, vt[i].e_stall);
            if (vt[i].v && vt[i].op == MEM_NONE) chk($sformatf("vec%0d.waddr", i), bus.mem_reg_waddr_o, vt[i].wa);
            @(negedge clk);
        end
        bus.dmem_gnt_i = 1'b0;

        txn("sb_wait", MEM_SB, 32'h103, 32'hAB, 0, 2, 0, 5'd1, 1'b1, 0, 4'h8, 32'hABAB_ABAB);
        txn("lb", MEM_LB, 32'h202, 0, 32'h0080_0000, 0, 0, 5'd7, 1'b1, 32'hFFFF_FF80, 4'hF, 0);
        txn("lbu", MEM_LBU, 32'h202, 0, 32'h0080_0000, 0, 0, 5'd7, 1'b1, 32'h0000_0080, 4'hF, 0);
        txn("lh", MEM_LH, 32'h2, 0, 32'h8001_0000, 0, 0, 5'd8, 1'b1, 32'hFFFF_8001, 4'hF, 0);
        txn("lhu", MEM_LHU, 32'h2, 0, 32'h8001_0000, 1, 2, 5'd8, 1'b1, 32'h0000_8001, 4'hF, 0);
        txn("lw_nowe", MEM_LW, 32'h400, 0, 32'h8765_4321, 2, 1, 5'd9, 1'b0, 32'h8765_4321, 4'hF, 0);

        drive(1'b1, MEM_LB, 32'h202, 0, 5'd7, 1'b1);
        bus.dmem_gnt_i = 1'b1;
        @(negedge clk);
        bus.dmem_gnt_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, MEM_NONE, 0, 0, 5'd0, 1'b0);
        bus.dmem_rvalid_i = 1'b1;
        bus.dmem_rdata_i = 32'h0080_0000;
        #1;
        chk_zero("late_rvalid");
        @(negedge clk);
        bus.dmem_rvalid_i = 1'b0;
        txn("after_rst", MEM_LBU, 32'h201, 0, 32'h0000_9900, 0, 0, 5'd3, 1'b1, 32'h0000_0099, 4'hF, 0);

`ifdef MEM_MISALIGN_TRAP_EN
        drive(1'b1, MEM_LW, 32'h102, 0, 5'd4, 1'b1);
        #1;
        chk("mis.req", bus.dmem_req_o, 0);
        chk("mis.flag", bus.mem_misalign_o, 1);
        chk("mis.valid", bus.mem_valid_o, 1);
        chk("mis.rwe", bus.mem_reg_we_o, 0);
        chk("mis.stall", bus.mem_stall_o, 0);
        @(negedge clk);
`else
        txn("lw_unaligned", MEM_LW, 32'h102, 0, 32'hA5A5_0F0F, 0, 0, 5'd4, 1'b1, 32'hA5A5_0F0F, 4'hF, 0);
        txn("sw_unaligned", MEM_SW, 32'h107, 32'h0BAD_F00D, 0, 1, 0, 5'd4, 1'b1, 0, 4'hF, 32'h0BAD_F00D);
`endif

        for (int n = 0; n < 80; n++) begin
            mem_op_t op = 4'($urandom_range(0, 8));
            logic [31:0] opc = $urandom;
            logic [31:0] sd = $urandom;
            logic [31:0] rdata = $urandom;
            logic [4:0] wa = 5'($urandom);
            logic we = 1'($urandom);
            logic [31:0] e_wb;
`ifdef MEM_MISALIGN_TRAP_EN
            if (op != MEM_NONE) opc = opc & ~32'd3;
`endif
            e_wb = op == MEM_NONE ? opc : m_store(op) ? 32'd0 : m_load(op, opc, rdata);
            txn($sformatf("rnd%0d", n), op, opc, sd, rdata, $urandom_range(0, 3), $urandom_range(0, 2),
                wa, we, e_wb, m_be(op, opc), m_wdata(op, sd));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
